// File: rtl/imem_pkg.sv
// imem_pkg: shared sizes, FSM encoding and constants for the instruction-memory loader.
package imem_pkg;
  localparam int DEPTH = 64;
  localparam int AW = 6;
  localparam logic [31:0] NOP = 32'h00000013;
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, DONE} state_t;
  function automatic logic [6:0] clamp_len(input logic [6:0] n);
    return (n > 7'(DEPTH)) ? 7'(DEPTH) : n;
  endfunction
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles four stream bytes into a little-endian word, first byte in the LSB.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_word,
  output logic        o_last
);
  logic [31:0] r_word;
  logic [1:0]  r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_en) begin
      r_word <= o_word;
      r_cnt  <= r_cnt + 2'd1;
    end
  end
  assign o_word = {i_data, r_word[31:8]};
  assign o_last = (r_cnt == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream writer for the 64-word instruction memory.
// Holds the core in reset during a load and releases it only on a good trailing checksum.
module imem_loader
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  n_words,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);
  state_t          r_state, w_state_nx;
  logic [6:0]      r_len;
  logic [AW-1:0]   r_idx;
  logic [7:0]      r_sum;
  logic [31:0]     w_word;
  logic            w_last, w_accept, w_start_ok, w_last_word;

  assign w_accept    = byte_valid && byte_ready;
  assign w_start_ok  = start && (r_state == IDLE || r_state == DONE);
  assign w_last_word = ({1'b0, r_idx} + 7'd1) == r_len;

  byte_packer u_packer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start_ok),
    .i_en  (r_state == RECV && w_accept),
    .i_data(byte_data),
    .o_word(w_word),
    .o_last(w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE, DONE: w_state_nx = start ? ((clamp_len(n_words) == 7'd0) ? CHK : RECV) : r_state;
      RECV:       w_state_nx = (w_accept && w_last) ? WRITE : RECV;
      WRITE:      w_state_nx = w_last_word ? CHK : RECV;
      CHK:        w_state_nx = w_accept ? DONE : CHK;
      default:    w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = (r_state == RECV) || (r_state == CHK);
  end

  // Registered outputs are driven from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_idx      <= '0;
      r_sum      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst_n <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we <= (w_state_nx == WRITE);
      busy   <= (w_state_nx == RECV) || (w_state_nx == WRITE) || (w_state_nx == CHK);
      if (w_start_ok) begin
        r_len      <= clamp_len(n_words);
        r_idx      <= '0;
        r_sum      <= '0;
        done       <= 1'b0;
        err        <= 1'b0;
        core_rst_n <= 1'b0;
      end
      if (r_state == RECV && w_accept) begin
        r_sum <= r_sum + byte_data;
        if (w_last) begin
          mem_addr  <= {24'b0, r_idx, 2'b00};
          mem_wdata <= w_word;
        end
      end
      if (r_state == WRITE && !w_last_word) r_idx <= r_idx + AW'(1);
      if (r_state == CHK && w_accept) begin
        done       <= (byte_data == r_sum);
        err        <= (byte_data != r_sum);
        core_rst_n <= (byte_data == r_sum);
      end
    end
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the 64-word instruction memory. It receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially from address 0 through a single-cycle write port. The block holds the core in reset while a load is in progress and verifies a trailing 8-bit checksum. It sits between a host link (UART/JTAG byte source) and the write side of instruction memory; the fetch path reads the same array.

## Interface
- DEPTH, 64, number of 32-bit words in instruction memory
- AW, 6, word-index width, equal to log2(DEPTH)

- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse that begins a load; honored only in IDLE or DONE
- n_words  input  7  number of words to load; sampled on an accepted start
- byte_valid  input  1  byte_data is valid
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts byte this cycle
- mem_we  output  1  write strobe to instruction memory
- mem_addr  output  32  byte address, word aligned: {24'b0, idx, 2'b00}
- mem_wdata  output  32  assembled instruction word
- core_rst_n  output  1  active-low reset to the core
- busy  output  1  load in progress
- done  output  1  last load finished with a good checksum
- err  output  1  last load finished with a bad checksum

## Operation
- States: IDLE, RECV, WRITE, CHK, DONE.
- IDLE/DONE, start=1: latch len = (n_words > DEPTH) ? DEPTH : n_words. Clear idx, byte counter, sum, done, err. Drive core_rst_n=0. Go to RECV, or to CHK if len==0.
- A byte is accepted when byte_valid && byte_ready. byte_ready=1 only in RECV and CHK.
- RECV: the k-th accepted byte (k=0..3) goes to word bits [8k+7:8k], so the first byte is the LSB. Each accepted byte is added into sum (mod 256). After byte 3, go to WRITE.
- WRITE: mem_we=1 for exactly one cycle, with mem_addr = idx*4 and mem_wdata = the assembled word. Then idx++. Next state is CHK if idx+1==len, else RECV.
- CHK: one accepted byte c. If c==sum: done=1, core_rst_n=1. Otherwise err=1 and core_rst_n stays 0. Go to DONE.
- DONE: hold all flags. start re-enters the load sequence. A failed load keeps the core in reset until a later successful load.
- start is ignored in RECV, WRITE and CHK. n_words is only sampled on an accepted start.
- busy=1 in RECV, WRITE and CHK.
- Reset values:
  - state=IDLE
  - byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
  - core_rst_n=1: the core runs the preloaded image when no load is requested
  - busy=0, done=0, err=0
- Reset mid-load returns to IDLE with core_rst_n=1. Partially written words remain in memory.

## Timing
- Outputs are registered, except byte_ready, which is decoded from state.
- With byte_valid held high: 4 cycles per byte group plus 1 WRITE cycle, so 5 cycles per word.
- A full 64-word load with no stalls takes 1 start cycle, then 320 cycles, then 1 CHK cycle.
- core_rst_n falls in the cycle after the accepted start. It rises in the cycle after a good checksum byte is accepted.
- No byte is accepted during WRITE. A source holding byte_valid keeps its byte until the loader returns to RECV.
- idx never exceeds DEPTH-1. The clamp guarantees no wrap.

## Structure
- Shared package `imem_pkg`: DEPTH, AW, state encoding (IDLE..DONE), NOP constant 32'h00000013.
- Single flat module. An optional sub-module `byte_packer` (4-byte shift/assemble with counter) is natural but not required.

## Test plan
- Load n_words=2 with bytes 13,00,00,00,93,00,10,00 and checksum B6. Expect mem_we pulses at mem_addr 0x0 (wdata 00000013) and 0x4 (wdata 00100093). Then done=1, err=0, core_rst_n=1.
- Same load with checksum B5. Expect err=1, done=0, core_rst_n held 0 in DONE.
- byte_valid toggled randomly during the load. Expect identical writes; no byte accepted while mem_we=1.
- n_words=0 followed by checksum 00. Expect no mem_we and done=1.
- n_words=100. Expect exactly 64 writes (last at mem_addr 0xFC), then CHK.
- start pulsed mid-RECV, then rst_n asserted mid-word. Expect the start to be ignored; on reset, state IDLE, busy=0, core_rst_n=1, and no further mem_we.
